axis_bram_pingpong_ctrl: RTL and testbench

//  Ping-pong write scheduler between the axis_bram_adapter output (DOUT_TO_BUF/DOUT_VALID/DOUT_ACCEP) and a dual-bank BRAM.

---
 rtl/axis_bram_pingpong_ctrl_pkg.sv | 16 +
 rtl/axis_bram_pingpong_ctrl_bank_flags.sv | 58 +++++
 rtl/axis_bram_pingpong_ctrl.sv | 140 ++++++++++++++
 tb/tb_axis_bram_pingpong_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong BRAM write scheduler: writer FSM
// state encodings and default geometry.
package axis_bram_pingpong_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FRAME_LEN  = 1024;

    // Writer state: FILL owns a free bank, WAIT_FREE waits for the consumer
    // to hand the next bank back.
    typedef enum logic {
        FILL      = 1'b0,
        WAIT_FREE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/axis_bram_pingpong_ctrl_bank_flags.sv
// Per-bank ownership flags and closed-bank length registers.
// A bank that is closed and released on the same edge stays owned by the
// consumer (set wins). The next-cycle flag values are exported so the writer
// FSM can decide on the closing edge whether the following bank is free.
module axis_bram_bank_flags
    import axis_bram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic                  set_bank,
    input  logic [ADDR_WIDTH:0]   set_len,
    input  logic [1:0]            release_i,
    output logic [1:0]            ready_o,
    output logic [1:0]            ready_next_o,
    output logic [ADDR_WIDTH:0]   len0_o,
    output logic [ADDR_WIDTH:0]   len1_o
);

    logic [1:0]          ready_q, ready_d;
    logic [ADDR_WIDTH:0] len0_q, len0_d;
    logic [ADDR_WIDTH:0] len1_q, len1_d;

    // Apply releases first, then the close so that a same-edge set wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        ready_d = ready_q & ~release_i;
        len0_d  = len0_q;
        len1_d  = len1_q;
        if (set_en) begin
            ready_d[set_bank] = 1'b1;
            if (set_bank) len1_d = set_len;
            else          len0_d = set_len;
        end
    end

    // Flag and length registers with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            ready_q <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
        end else begin
            ready_q <= ready_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
        end
    end

    assign ready_o      = ready_q;
    assign ready_next_o = ready_d;
    assign len0_o       = len0_q;
    assign len1_o       = len1_q;

endmodule

// File: rtl/axis_bram_pingpong_ctrl.sv
// Ping-pong write scheduler between the stream adapter and a dual-bank BRAM.
// Fills banks sequentially, closes a bank when full or on FLUSH, and stalls
// the adapter while both banks are owned by the consumer.
// Optional feature: define STALL_COUNTER_EN to build the saturating stall
// counter behind STALL_CNT; otherwise STALL_CNT is tied to zero.
module axis_bram_pingpong_ctrl
    import axis_bram_pingpong_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
    input  logic                  BUF_ACLK,
    input  logic                  BUF_ARESET,
    input  logic [DATA_WIDTH-1:0] DIN_FROM_ADP,
    input  logic                  DIN_VALID,
    output logic                  DIN_ACCEP,
    input  logic                  FLUSH,
    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH:0]   BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_WDATA,
    output logic [1:0]            BANK_READY,
    input  logic [1:0]            BANK_RELEASE,
    output logic [ADDR_WIDTH:0]   BANK0_LEN,
    output logic [ADDR_WIDTH:0]   BANK1_LEN,
    output logic [15:0]           STALL_CNT
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    wr_state_e             state_q, state_d;
    logic                  accep_q, accep_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_WIDTH:0]   bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;

    logic                  xfer;
    logic                  close;
    logic [ADDR_WIDTH:0]   close_len;
    logic [1:0]            ready_next;

    assign xfer      = DIN_VALID && accep_q;
    assign close_len = {1'b0, wr_addr_q} + {{ADDR_WIDTH{1'b0}}, xfer};
    // A flush only closes a bank that holds at least one word.
    assign close     = (xfer && (wr_addr_q == LAST_ADDR)) ||
                       (FLUSH && (state_q == FILL) && ((wr_addr_q != '0) || xfer));

    axis_bram_bank_flags #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_flags (
        .clk          (BUF_ACLK),
        .rst          (BUF_ARESET),
        .set_en       (close),
        .set_bank     (wr_bank_q),
        .set_len      (close_len),
        .release_i    (BANK_RELEASE),
        .ready_o      (BANK_READY),
        .ready_next_o (ready_next),
        .len0_o       (BANK0_LEN),
        .len1_o       (BANK1_LEN)
    );

    // Next-state, address counter and write-stage decode.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        bram_we_d    = xfer;
        bram_addr_d  = {wr_bank_q, wr_addr_q};
        bram_wdata_d = xfer ? DIN_FROM_ADP : bram_wdata_q;
        if (xfer) wr_addr_d = wr_addr_q + 1'b1;
        case (state_q)
            FILL: begin
                if (close) begin
                    wr_bank_d = ~wr_bank_q;
                    wr_addr_d = '0;
                    if (ready_next[~wr_bank_q]) state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (BANK_RELEASE[wr_bank_q]) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        // Accept is a registered decode so it never follows DIN_VALID and is low during reset.
        accep_d = (state_d == FILL);
    end

    // Writer state, address and BRAM write stage; reset drops any pending write.
    always_ff @(posedge BUF_ACLK) begin
        if (BUF_ARESET) begin
            state_q      <= FILL;
            accep_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            accep_q      <= accep_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
        end
    end

    assign DIN_ACCEP  = accep_q;
    assign BRAM_EN    = bram_we_q;
    assign BRAM_WE    = bram_we_q;
    assign BRAM_ADDR  = bram_addr_q;
    assign BRAM_WDATA = bram_wdata_q;

`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where the adapter offers data but is held off.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (DIN_VALID && !accep_q && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge BUF_ACLK) begin
        if (BUF_ARESET) stall_cnt_q <= '0;
        else            stall_cnt_q <= stall_cnt_d;
    end

    assign STALL_CNT = stall_cnt_q;
`else
    assign STALL_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_axis_bram_pingpong_ctrl.sv
// Self-checking bench for axis_bram_pingpong_ctrl (FRAME_LEN=4, ADDR_WIDTH=2).
// A bank-ownership model tracks fill counts and consumer ownership; a compare
// process checks every output on each falling edge, and directed scenarios
// pin the model with literal expectations before a randomized phase.
module tb_axis_bram_pingpong_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          dut_accep;
    logic          flush;
    logic          bram_en, bram_we;
    logic [AW:0]   bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [1:0]    bank_ready;
    logic [1:0]    bank_release;
    logic [AW:0]   bank0_len, bank1_len;
    logic [15:0]   stall_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    axis_bram_pingpong_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FRAME_LEN  (FL)
    ) dut (
        .BUF_ACLK     (clk),
        .BUF_ARESET   (rst),
        .DIN_FROM_ADP (din),
        .DIN_VALID    (din_valid),
        .DIN_ACCEP    (dut_accep),
        .FLUSH        (flush),
        .BRAM_EN      (bram_en),
        .BRAM_WE      (bram_we),
        .BRAM_ADDR    (bram_addr),
        .BRAM_WDATA   (bram_wdata),
        .BANK_READY   (bank_ready),
        .BANK_RELEASE (bank_release),
        .BANK0_LEN    (bank0_len),
        .BANK1_LEN    (bank1_len),
        .STALL_CNT    (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The writer owns the bank it is filling unless the consumer owns it;
    // the adapter is accepted exactly when the current bank is writer-owned,
    // except the first cycle after reset.
    bit [1:0]      m_rdy;
    int            m_len [2];
    int            m_bank, m_addr, m_cnt, m_waddr, m_stall;
    bit            m_acc, m_we, m_x;
    logic [DW-1:0] m_wdata;

    initial begin
        m_rdy = '0; m_len[0] = 0; m_len[1] = 0; m_bank = 0; m_addr = 0; m_cnt = 0;
        m_waddr = 0; m_stall = 0; m_acc = 0; m_we = 0; m_x = 0; m_wdata = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_rdy = '0; m_len[0] = 0; m_len[1] = 0; m_bank = 0; m_addr = 0;
            m_acc = 0; m_we = 0; m_stall = 0;
        end else begin
            m_x = din_valid && m_acc;
            if (din_valid && !m_acc && m_stall < 65535) m_stall++;
            m_we = m_x;
            if (m_x) begin
                m_waddr = m_bank * FL + m_addr;
                m_wdata = din;
            end
            m_cnt = m_addr + (m_x ? 1 : 0);
            m_rdy = m_rdy & ~bank_release;
            if (m_cnt == FL || (flush && m_cnt > 0)) begin
                m_rdy[m_bank] = 1'b1;
                m_len[m_bank] = m_cnt;
                m_bank = 1 - m_bank;
                m_addr = 0;
            end else begin
                m_addr = m_cnt;
            end
            m_acc = !m_rdy[m_bank];
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("accep",   dut_accep,  m_acc);
            check("bram_en", bram_en,    m_we);
            check("bram_we", bram_we,    m_we);
            if (m_we) begin
                check("bram_addr",  bram_addr,  m_waddr);
                check("bram_wdata", bram_wdata, m_wdata);
            end
            check("bank_ready", bank_ready, m_rdy);
            check("bank0_len",  bank0_len,  m_len[0]);
            check("bank1_len",  bank1_len,  m_len[1]);
`ifdef STALL_COUNTER_EN
            check("stall_cnt", stall_cnt, m_stall);
`else
            check("stall_cnt", stall_cnt, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs; x reports whether a transfer happens at the coming edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f,
                       input logic [1:0] rel, input logic r, output logic x);
        din_valid = v; din = d; flush = f; bank_release = rel; rst = r;
        x = v && dut_accep && !r;
        @(negedge clk);
    endtask

    // Offer one word until accepted, with a bounded wait.
    task automatic send(input logic [DW-1:0] d);
        logic x;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            cyc(1'b1, d, 1'b0, 2'b00, 1'b0, x);
            if (x) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %0h not accepted within 16 cycles", d);
        end
    endtask

    initial begin
        logic          x;
        logic [DW-1:0] cur;
        din_valid = 0; din = '0; flush = 0; bank_release = '0; rst = 1;

        // 1: reset, then four words fill bank 0
        cyc(1'b0, '0, 1'b0, 2'b00, 1'b1, x);
        cyc(1'b0, '0, 1'b0, 2'b00, 1'b1, x);
        chk_en = 1'b1;
        check("rst_ready", bank_ready, 2'b00);
        check("rst_len0",  bank0_len, 0);
        check("rst_we",    bram_we,   1'b0);
        check("rst_accep", dut_accep, 1'b0);
        for (int i = 0; i < 4; i++) send(DW'(i));
        check("s1_ready", bank_ready, 2'b01);
        check("s1_len0",  bank0_len,  4);
        check("s1_accep", dut_accep,  1'b1);
        check("s1_addr",  bram_addr,  3);
        check("s1_wdata", bram_wdata, 3);

        // 2: bank 1 fills with no release, adapter stalls
        for (int i = 4; i < 8; i++) send(DW'(i));
        check("s2_ready", bank_ready, 2'b11);
        check("s2_accep", dut_accep,  1'b0);
        check("s2_addr",  bram_addr,  7);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'd8, 1'b0, 2'b00, 1'b0, x);
        check("s2_held", dut_accep, 1'b0);

        // 3: release bank 0, word 8 lands at address 0
        cyc(1'b1, 32'd8, 1'b0, 2'b01, 1'b0, x);
        check("s3_accep", dut_accep,  1'b1);
        check("s3_ready", bank_ready, 2'b10);
        send(32'd8);
        check("s3_we",    bram_we,    1'b1);
        check("s3_addr",  bram_addr,  0);
        check("s3_wdata", bram_wdata, 8);

        // 4: flush partial bank 0 while releasing bank 1, then two words and a flush
        cyc(1'b0, '0, 1'b1, 2'b10, 1'b0, x);
        check("s4_ready_a", bank_ready, 2'b01);
        check("s4_len0",    bank0_len,  1);
        send(32'hA);
        send(32'hB);
        cyc(1'b0, '0, 1'b1, 2'b01, 1'b0, x);
        check("s4_ready_b", bank_ready, 2'b10);
        check("s4_len1",    bank1_len,  2);
        cyc(1'b0, '0, 1'b1, 2'b00, 1'b0, x);
        check("s4_empty_ready", bank_ready, 2'b10);
        check("s4_empty_len1",  bank1_len,  2);
        send(32'hC);
        check("s4_next_addr", bram_addr, 0);

        // 5: reset mid-frame
        send(32'hD);
        cyc(1'b1, 32'hE, 1'b0, 2'b00, 1'b1, x);
        check("s5_we",    bram_we,    1'b0);
        check("s5_ready", bank_ready, 2'b00);
        check("s5_len0",  bank0_len,  0);
        check("s5_len1",  bank1_len,  0);
        check("s5_accep", dut_accep,  1'b0);
        cyc(1'b1, 32'hE, 1'b0, 2'b00, 1'b0, x);
        check("s5_accep_after", dut_accep, 1'b1);
        send(32'hE);
        check("s5_addr", bram_addr, 0);

        // 6: five stalled cycles in WAIT_FREE
        cyc(1'b0, '0, 1'b0, 2'b00, 1'b1, x);
        cyc(1'b0, '0, 1'b0, 2'b00, 1'b0, x);
        for (int i = 16; i < 24; i++) send(DW'(i));
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'd99, 1'b0, 2'b00, 1'b0, x);
`ifdef STALL_COUNTER_EN
        check("s6_stall", stall_cnt, 5);
`else
        check("s6_stall", stall_cnt, 0);
`endif
        cyc(1'b0, '0, 1'b0, 2'b11, 1'b0, x);

        // Randomized phase
        cur = $urandom;
        for (int i = 0; i < 1500; i++) begin
            logic          v, f, r;
            logic [1:0]    rel;
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 199) == 0);
            rel = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            cyc(v, cur, f, rel, r, x);
            if (x) cur = $urandom;
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
